// File: rtl/poly_pointwise_montgomery_seq.sv
// Pointwise Montgomery multiply (optionally accumulate) of two degree-256
// polynomials mod Q, LANES coefficients per cycle through a 3-stage pipeline.
module poly_pointwise_montgomery_seq #(
  parameter int LANES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [8191:0] linear_a,
  input  logic [8191:0] linear_b,
  input  logic [8191:0] linear_acc,
  output logic          busy,
  output logic          done,
  output logic [8191:0] linear_c
);

  localparam int N    = 256;
  localparam int G    = N / LANES;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int Q    = 8380417;
  localparam logic [31:0] QINV = 32'd58728449;
  localparam logic [63:0] QW   = 64'(Q);
  localparam logic [GW:0]   GCNT  = (GW + 1)'(G);
  localparam logic [GW-1:0] GLAST = GW'(G - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  logic [8191:0] a_q, b_q, acc_q;
  logic          mode_q;
  logic [GW:0]   cnt;
  logic          accept, issue, last_wr;
  logic          s1_v, s2_v;
  logic [GW-1:0] s1_g, s2_g;
  logic [63:0]   s1_p [LANES];
  logic [63:0]   s2_p [LANES];
  logic [31:0]   s2_t [LANES];
  logic [31:0]   r    [LANES];

  assign accept  = (state == IDLE) && start;
  assign issue   = (state == RUN) && (cnt < GCNT);
  assign last_wr = s2_v && (s2_g == GLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start)   state_nx = RUN;
      RUN:  if (last_wr) state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Operand capture and datapath carry no reset; validity is tracked by s1_v/s2_v.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= linear_a;
      b_q    <= linear_b;
      acc_q  <= linear_acc;
      mode_q <= mode;
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      s1_p[l] <= {{32{a_q[(32'(cnt[GW-1:0]) * LANES + l) * 32 + 31]}},
                  a_q[(32'(cnt[GW-1:0]) * LANES + l) * 32 +: 32]}
               * {{32{b_q[(32'(cnt[GW-1:0]) * LANES + l) * 32 + 31]}},
                  b_q[(32'(cnt[GW-1:0]) * LANES + l) * 32 +: 32]};
      s2_p[l] <= s1_p[l];
      s2_t[l] <= s1_p[l][31:0] * QINV;
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      r[l] = 32'((s2_p[l] - ({{32{s2_t[l][31]}}, s2_t[l]} * QW)) >> 32);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s1_g     <= '0;
      s2_g     <= '0;
      done     <= 1'b0;
      linear_c <= '0;
    end else begin
      done <= last_wr;
      if (accept)     cnt <= '0;
      else if (issue) cnt <= cnt + 1'b1;
      s1_v <= issue;
      s1_g <= cnt[GW-1:0];
      s2_v <= s1_v;
      s2_g <= s1_g;
      if (s2_v) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          linear_c[(32'(s2_g) * LANES + l) * 32 +: 32] <= mode_q
            ? acc_q[(32'(s2_g) * LANES + l) * 32 +: 32] + r[l]
            : r[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_pointwise_montgomery_seq.sv
// Scoreboard bench for poly_pointwise_montgomery_seq: expected polynomials are
// queued at start and compared coefficient by coefficient when done pulses.
module tb_poly_pointwise_montgomery_seq;

  localparam int LANES = 4;
  localparam int N     = 256;
  localparam int G     = N / LANES;
  localparam int QM1   = 8380416;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [8191:0] linear_a = '0;
  logic [8191:0] linear_b = '0;
  logic [8191:0] linear_acc = '0;
  logic          busy, done;
  logic [8191:0] linear_c;

  int n_vec  = 0;
  int n_miss = 0;
  logic [8191:0] exp_q [$];

  always #5 clk = ~clk;

  poly_pointwise_montgomery_seq #(.LANES(LANES)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .linear_a   (linear_a),
    .linear_b   (linear_b),
    .linear_acc (linear_acc),
    .busy       (busy),
    .done       (done),
    .linear_c   (linear_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mont(input logic [31:0] a, input logic [31:0] b);
    longint p, rr;
    int     t;
    p  = longint'(signed'(a)) * longint'(signed'(b));
    t  = int'(p * 58728449);
    rr = (p - longint'(t) * 8380417) >>> 32;
    return 32'(rr);
  endfunction

  function automatic logic [8191:0] model(input logic m, input logic [8191:0] a,
                                          input logic [8191:0] b, input logic [8191:0] acc);
    logic [8191:0] c;
    for (int i = 0; i < N; i++) begin
      c[i*32 +: 32] = mont(a[i*32 +: 32], b[i*32 +: 32]);
      if (m) c[i*32 +: 32] = acc[i*32 +: 32] + c[i*32 +: 32];
    end
    return c;
  endfunction

  function automatic logic [8191:0] rand_vec();
    logic [8191:0] v;
    for (int i = 0; i < N; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [8191:0] rand_coef();
    logic [8191:0] v;
    for (int i = 0; i < N; i++) v[i*32 +: 32] = 32'(int'($urandom_range(2 * QM1, 0)) - QM1);
    return v;
  endfunction

  function automatic logic [8191:0] rep(input logic [31:0] x);
    logic [8191:0] v;
    for (int i = 0; i < N; i++) v[i*32 +: 32] = x;
    return v;
  endfunction

  // Drive a request in the current cycle, then scramble the inputs after acceptance.
  task automatic issue(input logic m, input logic [8191:0] a, input logic [8191:0] b,
                       input logic [8191:0] acc, input bit keep);
    mode = m; linear_a = a; linear_b = b; linear_acc = acc; start = 1'b1;
    if (keep) exp_q.push_back(model(m, a, b, acc));
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m; linear_a = rand_vec(); linear_b = rand_vec(); linear_acc = rand_vec();
  endtask

  task automatic wait_done(input int poke_at);
    int nb = 0;
    int k  = 0;
    logic [8191:0] want;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) check("done_pulse_width", 64'(done), 0);
      start = (i == poke_at);
      if (i == poke_at) begin
        mode = ~mode; linear_a = rand_vec(); linear_b = rand_vec();
      end
      if (done) begin
        k = i;
        break;
      end
      if (busy) nb++;
    end
    start = 1'b0;
    if (k == 0) begin
      check("done_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check("busy_width", 64'(nb), 64'(G + 2));
    check("done_latency", 64'(k), 64'(G + 3));
    if (exp_q.size() == 0) begin
      check("unexpected_done", 1, 0);
      return;
    end
    want = exp_q.pop_front();
    for (int i = 0; i < N; i++)
      check($sformatf("c[%0d]", i), 64'(linear_c[i*32 +: 32]), 64'(want[i*32 +: 32]));
  endtask

  initial begin
    logic [8191:0] accv;
    logic          seen;

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_c_nonzero", 64'(|linear_c), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, rep(32'd65536), rep(32'd65536), rand_vec(), 1'b1);
    wait_done(0);
    @(negedge clk);
    issue(1'b0, rep(32'hFFFF0000), rep(32'd65536), rand_vec(), 1'b1);
    wait_done(0);
    @(negedge clk);
    issue(1'b0, '0, '0, rand_vec(), 1'b1);
    wait_done(0);

    for (int i = 0; i < N; i++) accv[i*32 +: 32] = (i % 2 == 0) ? 32'd100 : 32'h7FFFFFFF;
    @(negedge clk);
    issue(1'b1, rep(32'd65536), rep(32'd65536), accv, 1'b1);
    wait_done(0);

    // Random, with a start pulse injected mid-run that must be ignored.
    @(negedge clk);
    issue(1'b0, rand_coef(), rand_coef(), rand_vec(), 1'b1);
    wait_done(10);
    seen = 1'b0;
    repeat (G + 5) begin
      @(negedge clk);
      seen |= done | busy;
    end
    check("no_queued_run", 64'(seen), 0);
    issue(1'b1, rand_coef(), rand_coef(), rand_vec(), 1'b1);
    wait_done(0);

    // Mid-run reset.
    @(negedge clk);
    issue(1'b1, rand_coef(), rand_coef(), rand_vec(), 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 0);
    check("midrst_done", 64'(done), 0);
    check("midrst_c_nonzero", 64'(|linear_c), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (G + 10) begin
      @(negedge clk);
      seen |= done | busy;
    end
    check("midrst_no_done", 64'(seen), 0);
    issue(1'b0, rand_coef(), rand_coef(), rand_vec(), 1'b1);
    wait_done(0);

    // Back-to-back: second start in the done cycle.
    @(negedge clk);
    issue(1'b1, rand_coef(), rand_coef(), rand_vec(), 1'b1);
    wait_done(0);
    issue(1'b0, rand_coef(), rand_coef(), rand_vec(), 1'b1);
    wait_done(0);
    @(negedge clk);
    check("final_done_clear", 64'(done), 0);
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
